// File: rtl/mam_wb_sram_if.sv
// rtl/mam_wb_sram_if.sv - Wishbone B3 bus bundle between a MAM master and the SRAM slave
interface mam_wb_sram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
);
    logic                    CYC_I;
    logic                    STB_I;
    logic                    WE_I;
    logic [ADDR_WIDTH-1:0]   ADR_I;
    logic [DATA_WIDTH-1:0]   DAT_I;
    logic [DATA_WIDTH/8-1:0] SEL_I;
    logic [2:0]              CTI_I;
    logic [1:0]              BTE_I;
    logic                    ACK_O;
    logic                    ERR_O;
    logic [DATA_WIDTH-1:0]   DAT_O;

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, CTI_I, BTE_I,
        output ACK_O, ERR_O, DAT_O
    );

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, CTI_I, BTE_I,
        input  ACK_O, ERR_O, DAT_O
    );
endinterface

// File: rtl/mam_wb_sram.sv
// rtl/mam_wb_sram.sv - Wishbone B3 SRAM slave with classic and CTI/BTE burst cycles
// Optional first-beat wait states are enabled by defining MAM_WB_SRAM_WAIT_EN.
module mam_wb_sram #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    mam_wb_sram_if.slave  wb
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BL = $clog2(NB);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_BURST  = 2'd2
`ifdef MAM_WB_SRAM_WAIT_EN
        , S_WAIT = 2'd3
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  oor_q, oor_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
`ifdef MAM_WB_SRAM_WAIT_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  burst_q, burst_d;
`endif

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic          resp_q;
    logic          last_beat;
    logic          burst_req;
    logic [AW-1:0] req_idx;
    logic          req_oor;
    logic [AW-1:0] addr_nxt;
    logic          wr_en;
    logic          rsp_en;
    logic [AW-1:0] rsp_idx;

    generate
        if (BL > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^wb.ADR_I[BL-1:0];
        end
    endgenerate

    function automatic logic [AW-1:0] advance(input logic [AW-1:0] a, input logic [1:0] bte);
        logic [AW-1:0] m;
        case (bte)
            2'b01:   m = AW'(3);
            2'b10:   m = AW'(7);
            2'b11:   m = AW'(15);
            default: m = '1;
        endcase
        return (a & ~m) | ((a + AW'(1)) & m);
    endfunction

    assign resp_q    = ack_q | err_q;
    assign last_beat = (wb.CTI_I == 3'b111);
    assign burst_req = (wb.CTI_I == 3'b010);
    assign req_idx   = wb.ADR_I[BL +: AW];
    assign req_oor   = |wb.ADR_I[ADDR_WIDTH-1:BL+AW];
    assign addr_nxt  = advance(addr_q, wb.BTE_I);
    // ERR beats never write: only a completing ACK beat commits.
    assign wr_en     = wb.CYC_I & wb.STB_I & ack_q & wb.WE_I;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
`ifdef MAM_WB_SRAM_WAIT_EN
            cnt_q   <= '0;
            burst_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
`ifdef MAM_WB_SRAM_WAIT_EN
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
`endif
        end
    end

    always_ff @(posedge CLK_I) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wb.SEL_I[b]) mem[addr_q][b*8 +: 8] <= wb.DAT_I[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!wb.CYC_I) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wb.STB_I) begin
`ifdef MAM_WB_SRAM_WAIT_EN
                        if (WAIT_CYCLES > 0) state_d = S_WAIT;
                        else                 state_d = burst_req ? S_BURST : S_SINGLE;
`else
                        state_d = burst_req ? S_BURST : S_SINGLE;
`endif
                    end
                end
                S_SINGLE: state_d = S_IDLE;
                S_BURST: begin
                    if (resp_q && wb.STB_I && last_beat) state_d = S_IDLE;
`ifdef MAM_WB_SRAM_WAIT_EN
                    else if (!resp_q && wb.STB_I && WAIT_CYCLES > 0) state_d = S_WAIT;
`endif
                end
`ifdef MAM_WB_SRAM_WAIT_EN
                S_WAIT: begin
                    if (cnt_q == '0 && wb.STB_I) state_d = burst_q ? S_BURST : S_SINGLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        addr_d  = addr_q;
        oor_d   = oor_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        rsp_en  = 1'b0;
        rsp_idx = addr_q;
`ifdef MAM_WB_SRAM_WAIT_EN
        cnt_d   = cnt_q;
        burst_d = burst_q;
`endif
        if (wb.CYC_I) begin
            case (state_q)
                S_IDLE: begin
                    if (wb.STB_I) begin
                        addr_d  = req_idx;
                        oor_d   = req_oor;
                        rsp_idx = req_idx;
`ifdef MAM_WB_SRAM_WAIT_EN
                        burst_d = burst_req;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                        rsp_en  = (WAIT_CYCLES == 0);
`else
                        rsp_en  = 1'b1;
`endif
                    end
                end
                S_BURST: begin
                    // Prefetch the advanced address so consecutive beats need no gap.
                    if (resp_q) begin
                        if (wb.STB_I && !last_beat) begin
                            addr_d  = addr_nxt;
                            rsp_idx = addr_nxt;
                            rsp_en  = 1'b1;
                        end
                    end else if (wb.STB_I) begin
`ifdef MAM_WB_SRAM_WAIT_EN
                        cnt_d  = CW'(WAIT_CYCLES - 1);
                        rsp_en = (WAIT_CYCLES == 0);
`else
                        rsp_en = 1'b1;
`endif
                    end
                end
`ifdef MAM_WB_SRAM_WAIT_EN
                S_WAIT: begin
                    if (cnt_q != '0)    cnt_d  = cnt_q - 1'b1;
                    else if (wb.STB_I)  rsp_en = 1'b1;
                end
`endif
                default: ;
            endcase
        end
        if (rsp_en) begin
            ack_d = !oor_d;
            err_d = oor_d;
            dat_d = oor_d ? '0 : mem[rsp_idx];
        end
    end

    assign wb.ACK_O = ack_q;
    assign wb.ERR_O = err_q;
    assign wb.DAT_O = dat_q;
endmodule

// File: tb/tb_mam_wb_sram.sv
// tb/tb_mam_wb_sram.sv - scoreboard bench for mam_wb_sram classic and burst cycles
module tb_mam_wb_sram;
    localparam int DW = 16;
    localparam int AWD = 32;
    localparam int NW = 1024;
`ifdef MAM_WB_SRAM_WAIT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mam_wb_sram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD)) wb();

    mam_wb_sram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .MEM_WORDS(NW), .WAIT_CYCLES(2)
    ) dut (
        .CLK_I(clk),
        .RST_I(rst),
        .wb(wb)
    );

    int total = 0;
    int bad = 0;
    logic [15:0] mdl [NW];
    logic [15:0] sb [$];
    logic [15:0] wq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_rd;
    always @(negedge clk) begin
        if (!rst && wb.CYC_I && wb.STB_I && !wb.WE_I && (wb.ACK_O || wb.ERR_O)) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'(1), 32'(0));
            end else begin
                exp_rd = sb.pop_front();
                check("rd_data", 32'(wb.DAT_O), 32'(exp_rd));
            end
        end
    end

    function automatic int burst_addr(input int w, input logic [1:0] bte, input int i);
        int n;
        case (bte)
            2'b01:   n = 4;
            2'b10:   n = 8;
            2'b11:   n = 16;
            default: return (w + i) % NW;
        endcase
        return (w / n) * n + ((w + i) % n);
    endfunction

    task automatic idle_bus();
        wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0; wb.ADR_I = '0;
        wb.DAT_I = '0;   wb.SEL_I = '0;   wb.CTI_I = '0;  wb.BTE_I = '0;
    endtask

    task automatic wait_resp(input string tag, input int exp_lat);
        int lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (wb.ACK_O || wb.ERR_O) begin
                lat = i;
                break;
            end
        end
        check(tag, 32'(lat), 32'(exp_lat));
    endtask

    task automatic wb_single(input bit we, input logic [31:0] adr, input logic [15:0] dat,
                             input logic [1:0] sel, input bit exp_err);
        int w;
        w = int'(adr[10:1]);
        @(posedge clk); #1;
        wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = we; wb.ADR_I = adr;
        wb.DAT_I = dat;  wb.SEL_I = sel;  wb.CTI_I = 3'b000; wb.BTE_I = 2'b00;
        if (!we) sb.push_back(exp_err ? 16'h0 : mdl[w]);
        wait_resp("single_lat", LAT);
        check("single_ack", 32'(wb.ACK_O), 32'(!exp_err));
        check("single_err", 32'(wb.ERR_O), 32'(exp_err));
        @(posedge clk); #1;
        if (we && !exp_err) begin
            if (sel[0]) mdl[w][7:0]  = dat[7:0];
            if (sel[1]) mdl[w][15:8] = dat[15:8];
        end
        idle_bus();
        @(negedge clk);
        check("single_ack_end", 32'(wb.ACK_O | wb.ERR_O), 32'(0));
    endtask

    task automatic wb_burst(input bit we, input logic [31:0] adr, input logic [1:0] bte,
                            input int n, input int gap_at);
        int w;
        int a;
        bit restart;
        w = int'(adr[10:1]);
        restart = 1'b1;
        @(posedge clk); #1;
        wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = we; wb.BTE_I = bte; wb.SEL_I = 2'b11;
        for (int i = 0; i < n; i++) begin
            a = burst_addr(w, bte, i);
            wb.CTI_I = (i == n - 1) ? 3'b111 : 3'b010;
            wb.ADR_I = 32'(a) << 1;
            wb.DAT_I = we ? wq[i] : 16'h0;
            if (!we) sb.push_back(mdl[a]);
            if (restart) begin
                wait_resp("burst_first_lat", LAT);
                restart = 1'b0;
            end else begin
                @(negedge clk);
                check("burst_ack", 32'(wb.ACK_O), 32'(1));
            end
            @(posedge clk); #1;
            if (we) mdl[a] = wq[i];
            if (i == gap_at) begin
                wb.STB_I = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("gap_ack", 32'(wb.ACK_O), 32'(0));
                @(posedge clk); #1;
                wb.STB_I = 1'b1;
                restart = 1'b1;
            end
        end
        wb.STB_I = 1'b0;
        @(negedge clk);
        check("burst_end_ack", 32'(wb.ACK_O), 32'(0));
        idle_bus();
    endtask

    initial begin
        rst = 1'b1;
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(wb.ACK_O), 32'(0));
        check("rst_err", 32'(wb.ERR_O), 32'(0));
        check("rst_dat", 32'(wb.DAT_O), 32'(0));
        rst = 1'b0;

        wb_single(1'b1, 32'h0, 16'h000F, 2'b11, 1'b0);
        wb_single(1'b0, 32'h0, 16'h0, 2'b00, 1'b0);

        wq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        wb_burst(1'b1, 32'h0, 2'b00, 6, -1);
        for (int i = 0; i < 6; i++) wb_single(1'b0, 32'(i) << 1, 16'h0, 2'b00, 1'b0);

        wb_burst(1'b0, 32'h4, 2'b01, 4, -1);

        wq = {};
        for (int i = 0; i < 8; i++) wq.push_back(16'($urandom));
        wb_burst(1'b1, 32'(13) << 1, 2'b10, 8, -1);
        wb_burst(1'b0, 32'(8) << 1, 2'b00, 8, -1);

        wb_single(1'b1, 32'h10, 16'h1234, 2'b11, 1'b0);
        wb_single(1'b1, 32'h10, 16'hABCD, 2'b01, 1'b0);
        wb_single(1'b0, 32'h10, 16'h0, 2'b00, 1'b0);
        check("sel_model", 32'(mdl[8]), 32'h12CD);
        wb_single(1'b1, 32'h0001_0010, 16'hFFFF, 2'b11, 1'b1);
        wb_single(1'b0, 32'h10, 16'h0, 2'b00, 1'b0);
        wb_single(1'b0, 32'h0001_0000, 16'h0, 2'b00, 1'b1);

        wb_burst(1'b0, 32'h0, 2'b00, 6, 2);

        @(posedge clk); #1;
        wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0; wb.ADR_I = '0;
        wb.CTI_I = 3'b010; wb.BTE_I = 2'b00;
        sb.push_back(mdl[0]);
        sb.push_back(mdl[1]);
        wait_resp("rst_burst_lat", LAT);
        @(posedge clk);
        @(negedge clk);
        check("rst_burst_ack", 32'(wb.ACK_O), 32'(1));
        #1 rst = 1'b1;
        #1;
        check("rst_mid_ack", 32'(wb.ACK_O), 32'(0));
        check("rst_mid_dat", 32'(wb.DAT_O), 32'(0));
        sb.delete();
        @(posedge clk); #1;
        idle_bus();
        rst = 1'b0;
        wb_single(1'b0, 32'h0000_000A, 16'h0, 2'b00, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
